// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants and types for the single-cycle RV32I core.
// The register file and the arithmetic_logic_unit both use word_t, so that
// register read data and ALU operands are always the same type.
//
// Optional build macro used by files importing this package: REGFILE_BYPASS_EN
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : riscv_pkg

// File: rtl/register_file_if.sv
// register_file_if
// Register-file access bundle between decode/writeback and the storage.
//   A1, A2 : read addresses (rs1, rs2)
//   A3     : write address (rd)
//   WD3    : write data (ALUResult, load data or PC+4)
//   WE3    : write enable (RegWrite)
//   RD1    : read data port 1 (ALU in1)
//   RD2    : read data port 2 (ALU in2 mux / store data)
// master : the core datapath that drives addresses and write data
// slave  : the register file itself
interface register_file_if;
    import riscv_pkg::*;

    reg_addr_t A1;
    reg_addr_t A2;
    reg_addr_t A3;
    word_t     WD3;
    logic      WE3;
    word_t     RD1;
    word_t     RD2;

    modport master (
        output A1, A2, A3, WD3, WE3,
        input  RD1, RD2
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3,
        output RD1, RD2
    );

endinterface : register_file_if

// File: rtl/register_file_read_port.sv
// regfile_read_port
// One combinational read port of the register file: selects an entry from
// the storage array, forces x0 to zero and, when REGFILE_BYPASS_EN is
// defined, forwards the in-flight write data on an address match.
//   rd_addr  : register to read
//   mem_q    : current contents of the storage array
//   wr_en    : qualified write enable (bypass build only)
//   wr_addr  : write address (bypass build only)
//   wr_data  : write data (bypass build only)
//   rd_data  : read result
// Macro: REGFILE_BYPASS_EN enables write-first forwarding.
module regfile_read_port
    import riscv_pkg::*;
(
    input  reg_addr_t rd_addr,
    input  word_t     mem_q [NREGS],
`ifdef REGFILE_BYPASS_EN
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
`endif
    output word_t     rd_data
);

    always_comb begin
        rd_data = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // Write-first: the value being written this cycle wins over storage.
        if (wr_en && (wr_addr != ZERO_REG) && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
`endif
        // x0 reads as zero regardless of storage or forwarding.
        if (rd_addr == ZERO_REG) begin
            rd_data = '0;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// register_file
// RV32I integer register file x0..x31: two combinational read ports and one
// synchronous write port. x0 is hardwired to zero.
//   clk   : core clock, writes on rising edge
//   rst_n : asynchronous active-low reset, clears every entry
//   bus   : register_file_if.slave (A1/A2/A3/WD3/WE3 in, RD1/RD2 out)
// Macro: REGFILE_BYPASS_EN -- when defined, a same-cycle write to a register
// being read is forwarded to RD1/RD2; otherwise reads return the old value
// until the clock edge.
module register_file
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    register_file_if.slave        bus
);

    word_t mem_q [NREGS];
    word_t mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        // Writes to x0 are discarded so the entry never leaves zero.
        if (bus.WE3 && (bus.A3 != ZERO_REG)) begin
            mem_d[bus.A3] = bus.WD3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // No write can happen while reset is held, so nothing is forwarded then.
    logic wr_fwd_en;
    assign wr_fwd_en = bus.WE3 && rst_n;
`endif

    regfile_read_port u_rd1 (
        .rd_addr (bus.A1),
        .mem_q   (mem_q),
`ifdef REGFILE_BYPASS_EN
        .wr_en   (wr_fwd_en),
        .wr_addr (bus.A3),
        .wr_data (bus.WD3),
`endif
        .rd_data (bus.RD1)
    );

    regfile_read_port u_rd2 (
        .rd_addr (bus.A2),
        .mem_q   (mem_q),
`ifdef REGFILE_BYPASS_EN
        .wr_en   (wr_fwd_en),
        .wr_addr (bus.A3),
        .wr_data (bus.WD3),
`endif
        .rd_data (bus.RD2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// tb_register_file
// Self-checking bench for register_file: directed checks followed by random
// traffic compared against an array model of the 32 architectural registers.
`timescale 1ns/1ps
module tb_register_file;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;

    register_file_if rf_if ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if.slave)
    );

    int    compared   = 0;
    int    mismatched = 0;
    word_t model [NREGS];

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Architectural read as the ISA sees it: x0 is zero, otherwise the stored
    // value, or the value being written when forwarding is built in.
    function automatic word_t refRead(input logic [4:0] a, input logic we,
                                      input logic [4:0] wa, input word_t wd,
                                      input logic rn);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rn && we && (wa != 5'd0) && (wa == a)) return wd;
`endif
        return model[a];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    endtask

    task automatic applyStimulus(input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [4:0] a3, input word_t wd,
                                 input logic we);
        @(negedge clk);
        rf_if.A1  = a1;
        rf_if.A2  = a2;
        rf_if.A3  = a3;
        rf_if.WD3 = wd;
        rf_if.WE3 = we;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        if (rst_n && rf_if.WE3 && (rf_if.A3 != 5'd0)) model[rf_if.A3] = rf_if.WD3;
        #1;
    endtask

    task automatic checkValue(input string tag, input word_t got, input word_t want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    task automatic checkOutput(input string tag);
        word_t e1, e2;
        #1;
        e1 = refRead(rf_if.A1, rf_if.WE3, rf_if.A3, rf_if.WD3, rst_n);
        e2 = refRead(rf_if.A2, rf_if.WE3, rf_if.A3, rf_if.WD3, rst_n);
        checkValue({tag, "_RD1"}, rf_if.RD1, e1);
        checkValue({tag, "_RD2"}, rf_if.RD2, e2);
    endtask

    initial begin
        logic [4:0] ra1, ra2, wa;
        word_t      raw_pre;

        // Power-up reset
        clearModel();
        rst_n     = 1'b0;
        rf_if.A1  = 5'd3;
        rf_if.A2  = 5'd9;
        rf_if.A3  = 5'd0;
        rf_if.WD3 = 32'h0;
        rf_if.WE3 = 1'b0;
        #2;
        checkValue("reset_RD1", rf_if.RD1, 32'h0);
        checkValue("reset_RD2", rf_if.RD2, 32'h0);
        #28;
        rst_n = 1'b1;

        // Basic write/read
        applyStimulus(5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1);
        clockEdge();
        applyStimulus(5'd5, 5'd5, 5'd0, 32'h0, 1'b0);
        #1;
        checkValue("basic_RD1", rf_if.RD1, 32'hDEADBEEF);
        checkValue("basic_RD2", rf_if.RD2, 32'hDEADBEEF);

        // Writes to x0 are dropped
        applyStimulus(5'd0, 5'd5, 5'd0, 32'hFFFFFFFF, 1'b1);
        clockEdge();
        applyStimulus(5'd0, 5'd5, 5'd0, 32'h0, 1'b0);
        #1;
        checkValue("x0_RD1", rf_if.RD1, 32'h0);
        checkValue("x0_other_RD2", rf_if.RD2, 32'hDEADBEEF);

        // WE3 low leaves state untouched
        applyStimulus(5'd7, 5'd7, 5'd7, 32'h12345678, 1'b0);
        clockEdge();
        #1;
        checkValue("we_gate_RD1", rf_if.RD1, 32'h0);

        // Same-cycle read-after-write
        applyStimulus(5'd0, 5'd0, 5'd3, 32'h1, 1'b1);
        clockEdge();
        applyStimulus(5'd3, 5'd3, 5'd3, 32'h2, 1'b1);
        #1;
`ifdef REGFILE_BYPASS_EN
        raw_pre = 32'h2;
`else
        raw_pre = 32'h1;
`endif
        checkValue("raw_before_RD1", rf_if.RD1, raw_pre);
        clockEdge();
        applyStimulus(5'd3, 5'd3, 5'd0, 32'h0, 1'b0);
        #1;
        checkValue("raw_after_RD1", rf_if.RD1, 32'h2);

        // Full sweep: every register gets a distinct value
        for (int i = 1; i < NREGS; i++) begin
            applyStimulus(5'd0, 5'd0, 5'(i), 32'hA000_0000 + 32'(i), 1'b1);
            clockEdge();
        end
        for (int i = 0; i < NREGS; i++) begin
            applyStimulus(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);
            #1;
            checkValue("sweep_RD1", rf_if.RD1, (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i));
            checkValue("sweep_RD2", rf_if.RD2, (i == 31) ? 32'h0 : 32'hA000_0000 + 32'(31 - i));
        end

        // Random traffic, biased so reads often hit the written register
        for (int n = 0; n < 300; n++) begin
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            applyStimulus(ra1, ra2, wa, word_t'($urandom), 1'($urandom_range(0, 1)));
            checkOutput("rand");
            clockEdge();
        end

        // Reset asserted mid-cycle clears everything before any edge
        applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        #10;
        rst_n = 1'b0;
        clearModel();
        for (int i = 1; i < NREGS; i++) begin
            rf_if.A1 = 5'(i);
            rf_if.A2 = 5'(32 - i);
            #1;
            checkValue("midreset_RD1", rf_if.RD1, 32'h0);
            checkValue("midreset_RD2", rf_if.RD2, 32'h0);
        end
        #4;
        rst_n = 1'b1;

        // Reset held across a write edge: the write is lost
        applyStimulus(5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 1'b1);
        #20;
        rst_n = 1'b0;
        checkOutput("wreset_pre");
        clockEdge();
        checkValue("wreset_hold_RD1", rf_if.RD1, 32'h0);
        applyStimulus(5'd9, 5'd9, 5'd0, 32'h0, 1'b0);
        #10;
        rst_n = 1'b1;
        #1;
        checkValue("wreset_after_RD1", rf_if.RD1, 32'h0);

        // Traffic after reset release
        for (int n = 0; n < 60; n++) begin
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            applyStimulus(ra1, ra2, wa, word_t'($urandom), 1'($urandom_range(0, 1)));
            checkOutput("post_reset");
            clockEdge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_file
